// File: rtl/apb_mon_pkg.sv
// apb_mon_pkg
//   Shared types and helpers for the APB3 protocol monitor.
//   phase_e : bus phase decoded on every pclk edge (IDLE / SETUP / ACCESS)
//   err_e   : violation codes; the code value is also the bit index in err_sticky
//   ERR_NUM : number of distinct violation codes
//   ERR_W   : width of an encoded violation code
//   phase_of()   : decodes psel/pen into a phase
//   lowest_err() : picks the lowest-numbered set bit of a violation vector
package apb_mon_pkg;

  localparam int ERR_NUM = 5;
  localparam int ERR_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } phase_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NO_ACCESS  = 3'd0,  // SETUP or stalled ACCESS not followed by ACCESS
    ERR_UNSTABLE   = 3'd1,  // address/direction/write data moved inside a transfer
    ERR_PEN_NO_SEL = 3'd2,  // penable asserted without psel
    ERR_TIMEOUT    = 3'd3,  // too many wait states
    ERR_NO_SETUP   = 3'd4   // ACCESS without a preceding SETUP
  } err_e;

  function automatic phase_e phase_of(input logic sel, input logic en);
    phase_e ph;
    if (!sel) begin
      ph = IDLE;
    end else if (!en) begin
      ph = SETUP;
    end else begin
      ph = ACCESS;
    end
    return ph;
  endfunction

  // Scan from the top down so the last hit is the lowest index.
  function automatic logic [ERR_W-1:0] lowest_err(input logic [ERR_NUM-1:0] v);
    logic [ERR_W-1:0] code;
    code = '0;
    for (int i = ERR_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        code = ERR_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// apb_mon_sat_cnt
//   Saturating up-counter with synchronous clear. Clear has priority over
//   increment; the count sticks at all-ones instead of wrapping.
//   Ports:
//     clk   in  1  clock
//     rst_n in  1  asynchronous reset, active-low
//     clr   in  1  synchronous clear
//     inc   in  1  increment request
//     q     out W  current count
module apb_mon_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor
//   Passive APB3 protocol monitor. Decodes every pclk edge into IDLE / SETUP /
//   ACCESS, checks phase ordering, in-transfer signal stability and wait-state
//   timeout, reports violations (pulse + lowest code + sticky vector) and
//   publishes every cleanly completed transfer.
//   Build option: define APB_MON_STATS_EN to enable the saturating
//   wr_count / rd_count / err_count statistics; otherwise they read 0.
//   Ports:
//     pclk, prst                  clock, asynchronous active-low reset
//     paddr, pwrite, psel, pen,
//     pwdata, prdata, pready,
//     pslverr                     tapped APB signals (inputs only)
//     clr_err                     clears err_sticky (a same-edge violation still sets)
//     err_valid, err_code         one-cycle violation pulse and lowest code
//     err_sticky                  accumulated violations, bit n = code n
//     xfer_valid, xfer_write,
//     xfer_addr, xfer_data,
//     xfer_err                    completed-transfer record, one cycle after pready
//     wr_count, rd_count,
//     err_count                   statistics counters
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic                 pwrite,
  input  logic                 psel,
  input  logic                 pen,
  input  logic [DATA_W-1:0]    pwdata,
  input  logic [DATA_W-1:0]    prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  input  logic                 clr_err,
  output logic                 err_valid,
  output logic [ERR_W-1:0]     err_code,
  output logic [ERR_NUM-1:0]   err_sticky,
  output logic                 xfer_valid,
  output logic                 xfer_write,
  output logic [ADDR_W-1:0]    xfer_addr,
  output logic [DATA_W-1:0]    xfer_data,
  output logic                 xfer_err,
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     err_count
);

  // wait_cnt must be able to hold MAX_WAIT itself: it parks there after a
  // timeout so the violation is reported only once per transfer.
  localparam int              WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(MAX_WAIT);

  phase_e              cur_phase;
  phase_e              prev_phase_reg;
  logic                prev_pready_reg;
  logic [ADDR_W-1:0]   cap_addr_reg;
  logic                cap_write_reg;
  logic [DATA_W-1:0]   cap_wdata_reg;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                pending;
  logic                changed;
  logic                stall;
  logic                complete;
  logic                capture;
  logic [ERR_NUM-1:0]  viol;

  // ---------------------------------------------------------------------------
  // Per-edge classification and violation detection
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_phase = phase_of(psel, pen);

    // A transfer is "open" if the last edge was SETUP or an ACCESS that
    // the slave stalled; the current edge must then be the (same) ACCESS.
    pending = (prev_phase_reg == SETUP) ||
              ((prev_phase_reg == ACCESS) && !prev_pready_reg);

    // Write data only matters for writes; read transfers may drive anything.
    changed = (paddr != cap_addr_reg) || (pwrite != cap_write_reg) ||
              (cap_write_reg && (pwdata != cap_wdata_reg));

    stall = (cur_phase == ACCESS) && !pready;

    viol                 = '0;
    viol[ERR_NO_ACCESS]  = pending && (cur_phase != ACCESS);
    viol[ERR_UNSTABLE]   = pending && (cur_phase == ACCESS) && changed;
    viol[ERR_PEN_NO_SEL] = pen && !psel;
    viol[ERR_TIMEOUT]    = stall && (wait_cnt == WAIT_LAST);
    viol[ERR_NO_SETUP]   = (cur_phase == ACCESS) &&
                           ((prev_phase_reg == IDLE) ||
                            ((prev_phase_reg == ACCESS) && prev_pready_reg));

    complete = (cur_phase == ACCESS) && pready && (viol == '0);

    // Re-capturing on an orphan ACCESS lets stability checks continue on
    // its wait states rather than comparing against a stale transfer.
    capture = (cur_phase == SETUP) || viol[ERR_NO_SETUP];
  end

  // ---------------------------------------------------------------------------
  // Wait-state counter: counts stalled ACCESS samples, holds at MAX_WAIT,
  // clears on any sample that is not a stall.
  // ---------------------------------------------------------------------------
  apb_mon_sat_cnt #(
    .W (WAIT_W)
  ) u_wait_cnt (
    .clk   (pclk),
    .rst_n (prst),
    .clr   (!stall),
    .inc   (stall && (wait_cnt != WAIT_TOP)),
    .q     (wait_cnt)
  );

  // ---------------------------------------------------------------------------
  // Tracking state, violation reporting and transfer publication
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      prev_phase_reg  <= IDLE;
      prev_pready_reg <= 1'b0;
      cap_addr_reg    <= '0;
      cap_write_reg   <= 1'b0;
      cap_wdata_reg   <= '0;
      err_valid       <= 1'b0;
      err_code        <= '0;
      err_sticky      <= '0;
      xfer_valid      <= 1'b0;
      xfer_write      <= 1'b0;
      xfer_addr       <= '0;
      xfer_data       <= '0;
      xfer_err        <= 1'b0;
    end else begin
      prev_phase_reg  <= cur_phase;
      prev_pready_reg <= pready;

      if (capture) begin
        cap_addr_reg  <= paddr;
        cap_write_reg <= pwrite;
        cap_wdata_reg <= pwdata;
      end

      err_valid <= |viol;
      err_code  <= lowest_err(viol);
      // Clear first, then OR in this edge's violations so they are never lost.
      err_sticky <= (clr_err ? '0 : err_sticky) | viol;

      xfer_valid <= complete;
      if (complete) begin
        xfer_write <= pwrite;
        xfer_addr  <= paddr;
        xfer_data  <= pwrite ? pwdata : prdata;
        xfer_err   <= pslverr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: index 0 = writes, 1 = reads, 2 = violation pulses
  // ---------------------------------------------------------------------------
`ifdef APB_MON_STATS_EN
  logic [2:0]       stat_inc;
  logic [CNT_W-1:0] stat_q [3];

  assign stat_inc[0] = xfer_valid && xfer_write;
  assign stat_inc[1] = xfer_valid && !xfer_write;
  assign stat_inc[2] = err_valid;

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    apb_mon_sat_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (pclk),
      .rst_n (prst),
      .clr   (1'b0),
      .inc   (stat_inc[gi]),
      .q     (stat_q[gi])
    );
  end

  assign wr_count  = stat_q[0];
  assign rd_count  = stat_q[1];
  assign err_count = stat_q[2];
`else
  assign wr_count  = '0;
  assign rd_count  = '0;
  assign err_count = '0;
`endif

endmodule
